prbs_checker: RTL and testbench

//  Receive-side checker for the serial PRBS stream produced by our 4-bit Fibonacci LFSR generator
//  (serial bit = generator MSB, feedback = MSB ^ MSB-1, so s(n) = s(n-4) ^ s(n-3)).

---
 rtl/prbs_pkg.sv | 13 +
 rtl/prbs_if.sv | 24 ++
 rtl/prbs_window_mon.sv | 44 ++++
 rtl/prbs_checker.sv | 113 +++++++++++
 tb/tb_prbs_checker.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: checker state encoding and the default polynomial,
// common to the generator and the checker so both ends agree.
package prbs_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } prbs_state_t;

  localparam int unsigned              PRBS_WIDTH = 4;
  localparam logic [PRBS_WIDTH-1:0]    PRBS_TAPS  = 4'b1100;

endpackage

// File: rtl/prbs_if.sv
// Receive-side PRBS checker bus: serial data in, lock/error status out.
interface prbs_if #(
  parameter int unsigned ERR_CNT_W = 16
);

  logic                 din;
  logic                 din_valid;
  logic                 clr_cnt;
  logic                 locked;
  logic                 bit_err;
  logic                 lock_lost;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output din, din_valid, clr_cnt,
    input  locked, bit_err, lock_lost, err_cnt
  );

  modport slave (
    input  din, din_valid, clr_cnt,
    output locked, bit_err, lock_lost, err_cnt
  );

endinterface

// File: rtl/prbs_window_mon.sv
// Loss-of-lock monitor: counts errors inside fixed windows of valid bits and
// flags when the count including the current bit reaches the threshold.
module prbs_window_mon #(
  parameter int unsigned WINDOW     = 32,
  parameter int unsigned ERR_THRESH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic err,
  output logic lose_lock
);

  localparam int unsigned CW = $clog2(WINDOW);
  localparam int unsigned EW = $clog2(ERR_THRESH + 1);

  localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW - 1);
  localparam logic [EW-1:0] THRESH   = EW'(ERR_THRESH);

  logic [CW-1:0] win_cnt;
  logic [EW-1:0] win_err;
  logic [EW-1:0] err_next;

  // win_err stays below THRESH, so adding one bit cannot overflow EW bits
  assign err_next  = win_err + EW'(err);
  assign lose_lock = en && (err_next >= THRESH);

  // Counters return to zero on exit from lock, so they start clean at the next lock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt <= '0;
      win_err <= '0;
    end else if (en) begin
      if (lose_lock || (win_cnt == WIN_LAST)) begin
        win_cnt <= '0;
        win_err <= '0;
      end else begin
        win_cnt <= win_cnt + CW'(1);
        win_err <= err_next;
      end
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// PRBS receive checker: self-synchronises its LFSR from the line, declares lock,
// then flywheels the LFSR and counts bit errors until too many arrive in a window.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int unsigned      WIDTH      = PRBS_WIDTH,
  parameter logic [WIDTH-1:0] TAPS       = PRBS_TAPS,
  parameter int unsigned      LOCK_CNT   = 8,
  parameter int unsigned      WINDOW     = 32,
  parameter int unsigned      ERR_THRESH = 4,
  parameter int unsigned      ERR_CNT_W  = 16
) (
  input  logic  clk,
  input  logic  rst,
  prbs_if.slave bus
);

  localparam int unsigned FW = $clog2(WIDTH + 1);
  localparam int unsigned MW = $clog2(LOCK_CNT + 1);

  localparam logic [FW-1:0] FILL_DONE  = FW'(WIDTH);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);

  prbs_state_t          state;
  logic [WIDTH-1:0]     hist;
  logic [FW-1:0]        fill_cnt;
  logic [MW-1:0]        match_cnt;
  logic                 locked_q;
  logic                 bit_err_q;
  logic                 lock_lost_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  logic pred;
  logic mism;
  logic win_en;
  logic lose_lock;

  assign pred   = ^(hist & TAPS);
  assign mism   = bus.din != pred;
  assign win_en = bus.din_valid && (state == LOCKED);

  prbs_window_mon #(
    .WINDOW     (WINDOW),
    .ERR_THRESH (ERR_THRESH)
  ) u_window_mon (
    .clk       (clk),
    .rst       (rst),
    .en        (win_en),
    .err       (mism),
    .lose_lock (lose_lock)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SEARCH;
      hist        <= '0;
      fill_cnt    <= '0;
      match_cnt   <= '0;
      locked_q    <= 1'b0;
      bit_err_q   <= 1'b0;
      lock_lost_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      bit_err_q   <= 1'b0;
      lock_lost_q <= 1'b0;
      if (bus.clr_cnt)
        err_cnt_q <= '0;
      if (bus.din_valid) begin
        case (state)
          SEARCH: begin
            hist <= {hist[WIDTH-2:0], bus.din};
            if (fill_cnt != FILL_DONE) begin
              fill_cnt <= fill_cnt + FW'(1);
            end else if (!mism && (hist != '0)) begin
              if (match_cnt == MATCH_LAST) begin
                state     <= LOCKED;
                locked_q  <= 1'b1;
                match_cnt <= '0;
              end else begin
                match_cnt <= match_cnt + MW'(1);
              end
            end else begin
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            // Flywheel: line errors never enter the local LFSR
            hist <= {hist[WIDTH-2:0], pred};
            if (mism) begin
              bit_err_q <= 1'b1;
              if (!bus.clr_cnt && (err_cnt_q != '1))
                err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
            end
            if (lose_lock) begin
              state       <= SEARCH;
              locked_q    <= 1'b0;
              lock_lost_q <= 1'b1;
              fill_cnt    <= '0;
              match_cnt   <= '0;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  assign bus.locked    = locked_q;
  assign bus.bit_err   = bit_err_q;
  assign bus.lock_lost = lock_lost_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock acquisition, flywheel error counting,
// loss of lock, zero-stream rejection, gapped valid, counter clear and saturation.
module tb_prbs_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic clr_cnt = 1'b0;
  logic [3:0] gen = 4'b1010;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  prbs_if #(.ERR_CNT_W(16)) bus  ();
  prbs_if #(.ERR_CNT_W(2))  bus2 ();

  assign bus.din        = din;
  assign bus.din_valid  = din_valid;
  assign bus.clr_cnt    = clr_cnt;
  assign bus2.din       = din;
  assign bus2.din_valid = din_valid;
  assign bus2.clr_cnt   = clr_cnt;

  prbs_checker #(
    .WIDTH(4), .TAPS(4'b1100), .LOCK_CNT(8), .WINDOW(32), .ERR_THRESH(4), .ERR_CNT_W(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  prbs_checker #(
    .WIDTH(4), .TAPS(4'b1100), .LOCK_CNT(8), .WINDOW(32), .ERR_THRESH(4), .ERR_CNT_W(2)
  ) dut_w2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic b, input logic v, input logic c);
    din       = b;
    din_valid = v;
    clr_cnt   = c;
    @(posedge clk);
    #1;
  endtask

  // Generator model: serial bit = MSB, feedback = MSB ^ MSB-1
  task automatic send(input logic inv, input logic c);
    logic b;
    b   = gen[3];
    gen = {gen[2:0], gen[3] ^ gen[2]};
    step(b ^ inv, 1'b1, c);
  endtask

  task automatic do_reset();
    din       = 1'b0;
    din_valid = 1'b0;
    clr_cnt   = 1'b0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    gen = 4'b1010;
  endtask

  task automatic lock_up();
    do_reset();
    for (int unsigned i = 1; i <= 12; i++)
      send(1'b0, 1'b0);
    check("lock_up_locked", 32'(bus.locked), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // 1: reset state and clean-stream lock at the 12th bit
    do_reset();
    check("rst_locked", 32'(bus.locked), 0);
    check("rst_bit_err", 32'(bus.bit_err), 0);
    check("rst_lock_lost", 32'(bus.lock_lost), 0);
    check("rst_err_cnt", 32'(bus.err_cnt), 0);
    for (int unsigned n = 1; n <= 200; n++) begin
      send(1'b0, 1'b0);
      check("t1_locked", 32'(bus.locked), 32'(n >= 12));
      check("t1_bit_err", 32'(bus.bit_err), 0);
    end
    check("t1_err_cnt", 32'(bus.err_cnt), 0);
    check("t1_lock_lost", 32'(bus.lock_lost), 0);

    // 2: single inverted bit, plus an ignored invalid cycle
    lock_up();
    for (int unsigned i = 0; i < 10; i++) begin
      send(1'b0, 1'b0);
      check("t2_pre_bit_err", 32'(bus.bit_err), 0);
    end
    send(1'b1, 1'b0);
    check("t2_bit_err", 32'(bus.bit_err), 1);
    check("t2_err_cnt", 32'(bus.err_cnt), 1);
    check("t2_locked", 32'(bus.locked), 1);
    step(~gen[3], 1'b0, 1'b0);
    check("t2_invalid_bit_err", 32'(bus.bit_err), 0);
    check("t2_invalid_err_cnt", 32'(bus.err_cnt), 1);
    for (int unsigned i = 0; i < 20; i++) begin
      send(1'b0, 1'b0);
      check("t2_post_bit_err", 32'(bus.bit_err), 0);
      check("t2_post_locked", 32'(bus.locked), 1);
    end
    check("t2_final_err_cnt", 32'(bus.err_cnt), 1);

    // 3: four errors inside one window force loss of lock, then re-lock
    lock_up();
    for (int unsigned i = 0; i < 5; i++)
      send(1'b0, 1'b0);
    for (int unsigned i = 1; i <= 4; i++) begin
      send(1'b1, 1'b0);
      check("t3_bit_err", 32'(bus.bit_err), 1);
      check("t3_lock_lost", 32'(bus.lock_lost), 32'(i == 4));
      check("t3_locked", 32'(bus.locked), 32'(i < 4));
      check("t3_err_cnt", 32'(bus.err_cnt), i);
      check("t3_w2_err_cnt", 32'(bus2.err_cnt), (i < 3) ? i : 3);
    end
    for (int unsigned i = 1; i <= 12; i++) begin
      send(1'b0, 1'b0);
      check("t3_relock", 32'(bus.locked), 32'(i == 12));
      check("t3_relock_lost", 32'(bus.lock_lost), 0);
      check("t3_search_bit_err", 32'(bus.bit_err), 0);
    end
    check("t3_final_err_cnt", 32'(bus.err_cnt), 4);

    // 4: three errors per window (straddling window boundaries) keep lock
    lock_up();
    for (int unsigned w = 0; w < 10; w++) begin
      for (int unsigned k = 0; k < 32; k++) begin
        logic inv;
        inv = (k == 0) || (k == 1) || (k == 31);
        send(inv, 1'b0);
        check("t4_bit_err", 32'(bus.bit_err), 32'(inv));
        check("t4_locked", 32'(bus.locked), 1);
      end
    end
    check("t4_err_cnt", 32'(bus.err_cnt), 30);
    check("t4_w2_saturated", 32'(bus2.err_cnt), 3);

    // 5: all-zero stream never locks; real stream then locks 12 bits later
    do_reset();
    for (int unsigned i = 0; i < 64; i++) begin
      step(1'b0, 1'b1, 1'b0);
      check("t5_zero_locked", 32'(bus.locked), 0);
      check("t5_zero_bit_err", 32'(bus.bit_err), 0);
    end
    gen = 4'b1010;
    for (int unsigned i = 1; i <= 12; i++) begin
      send(1'b0, 1'b0);
      check("t5_locked", 32'(bus.locked), 32'(i == 12));
      check("t5_bit_err", 32'(bus.bit_err), 0);
    end
    check("t5_err_cnt", 32'(bus.err_cnt), 0);

    // 6: gapped valid, clear-with-error, asynchronous reset while locked
    do_reset();
    for (int unsigned i = 1; i <= 12; i++) begin
      send(1'b0, 1'b0);
      check("t6_locked", 32'(bus.locked), 32'(i == 12));
      step(1'($urandom), 1'b0, 1'b0);
      check("t6_gap_locked", 32'(bus.locked), 32'(i == 12));
      check("t6_gap_bit_err", 32'(bus.bit_err), 0);
    end
    send(1'b1, 1'b0);
    check("t6_err_cnt", 32'(bus.err_cnt), 1);
    send(1'b1, 1'b1);
    check("t6_clr_bit_err", 32'(bus.bit_err), 1);
    check("t6_clr_err_cnt", 32'(bus.err_cnt), 0);
    check("t6_clr_w2_err_cnt", 32'(bus2.err_cnt), 0);
    check("t6_clr_locked", 32'(bus.locked), 1);
    send(1'b0, 1'b0);
    check("t6_after_clr_err_cnt", 32'(bus.err_cnt), 0);
    send(1'b1, 1'b0);
    check("t6_pre_rst_bit_err", 32'(bus.bit_err), 1);
    check("t6_pre_rst_locked", 32'(bus.locked), 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_locked", 32'(bus.locked), 0);
    check("t6_rst_bit_err", 32'(bus.bit_err), 0);
    check("t6_rst_lock_lost", 32'(bus.lock_lost), 0);
    check("t6_rst_err_cnt", 32'(bus.err_cnt), 0);
    check("t6_rst_w2_locked", 32'(bus2.locked), 0);
    @(posedge clk);
    #1;
    check("t6_rst_hold_locked", 32'(bus.locked), 0);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
